// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: accepts one LOAD/STORE from execute, runs the
// DMEM req/ack handshake on registered bus signals, and aborts accesses that never get an ack.
`timescale 1ns/1ps

package simple_processor_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
endpackage

module dmem_access_ctrl #(
  parameter int MEM_ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic                      ex_valid_i,
  input  logic                      ex_is_load_i,
  input  logic                      ex_is_store_i,
  input  logic [MEM_ADDR_WIDTH-1:0] ex_addr_i,
  input  logic [MEM_DATA_WIDTH-1:0] ex_wdata_i,
  output logic                      stall_o,
  output logic [MEM_DATA_WIDTH-1:0] rd_data_o,
  output logic                      rd_valid_o,
  output logic                      err_o,
  output logic                      dmem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] dmem_addr_o,
  output logic                      dmem_we_o,
  output logic [MEM_DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic [MEM_DATA_WIDTH-1:0] dmem_rdata_i,
  input  logic                      dmem_ack_i,
  output logic [1:0]                dbg_state_o
);

  // Handshake: dmem_req_o stays high with addr/we/wdata frozen until dmem_ack_i
  // is seen high on a rising edge; the ack cycle is the last WAIT_ACK cycle.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RESP     = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MEM_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                      we_q, we_d;
  logic                      abort_q, abort_d;
  logic                      ill_q, ill_d;

  logic one_hot_op;
  logic accept;
  logic illegal;
  logic timeout_hit;

  assign one_hot_op  = ex_is_load_i ^ ex_is_store_i;
  assign accept      = (state_q == IDLE) && ex_valid_i && one_hot_op;
  assign illegal     = (state_q == IDLE) && ex_valid_i && !one_hot_op;
  assign timeout_hit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      we_q      <= 1'b0;
      abort_q   <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      we_q      <= we_d;
      abort_q   <= abort_d;
      ill_q     <= ill_d;
    end
  end

  // An ack in the final counted cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = WAIT_ACK;
      WAIT_ACK: if (dmem_ack_i || timeout_hit) state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = '0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    we_d      = we_q;
    abort_d   = abort_q;
    ill_d     = illegal;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = ex_addr_i;
          we_d    = ex_is_store_i;
          abort_d = 1'b0;
          if (ex_is_store_i) wdata_d = ex_wdata_i;
        end
      end
      WAIT_ACK: begin
        cnt_d = cnt_q + 8'd1;
        if (dmem_ack_i) begin
          abort_d = 1'b0;
          if (!we_q) rd_data_d = dmem_rdata_i;
        end else if (timeout_hit) begin
          abort_d   = 1'b1;
          rd_data_d = '0;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_comb begin
    stall_o    = 1'b0;
    dmem_req_o = 1'b0;
    rd_valid_o = 1'b0;
    err_o      = ill_q;
    case (state_q)
      IDLE:     stall_o = accept;
      WAIT_ACK: begin
        stall_o    = 1'b1;
        dmem_req_o = 1'b1;
      end
      RESP: begin
        rd_valid_o = !we_q;
        err_o      = ill_q | abort_q;
      end
      default: ;
    endcase
  end

  assign rd_data_o    = rd_data_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_we_o    = we_q;
  assign dmem_wdata_o = wdata_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed and randomized bench for dmem_access_ctrl; expectations come from a
// transaction-level model (wait-cycle count, abort decision, last-value registers).
`timescale 1ns/1ps

module tb_dmem_access_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk_i = 1'b0;
  logic          arst_ni = 1'b0;
  logic          ex_valid_i = 1'b0;
  logic          ex_is_load_i = 1'b0;
  logic          ex_is_store_i = 1'b0;
  logic [AW-1:0] ex_addr_i = '0;
  logic [DW-1:0] ex_wdata_i = '0;
  logic          stall_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          err_o;
  logic          dmem_req_o;
  logic [AW-1:0] dmem_addr_o;
  logic          dmem_we_o;
  logic [DW-1:0] dmem_wdata_o;
  logic [DW-1:0] dmem_rdata_i = '0;
  logic          dmem_ack_i = 1'b0;
  logic [1:0]    dbg_state_o;

  dmem_access_ctrl #(
    .MEM_ADDR_WIDTH(AW),
    .MEM_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i         (clk_i),
    .arst_ni       (arst_ni),
    .ex_valid_i    (ex_valid_i),
    .ex_is_load_i  (ex_is_load_i),
    .ex_is_store_i (ex_is_store_i),
    .ex_addr_i     (ex_addr_i),
    .ex_wdata_i    (ex_wdata_i),
    .stall_o       (stall_o),
    .rd_data_o     (rd_data_o),
    .rd_valid_o    (rd_valid_o),
    .err_o         (err_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_rdata_i  (dmem_rdata_i),
    .dmem_ack_i    (dmem_ack_i),
    .dbg_state_o   (dbg_state_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Model of the architecturally visible "last value" registers.
  logic [DW-1:0] exp_rd_data = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic          exp_we = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req"}, dmem_req_o, 1'b0);
    chk({tag, "_stall"}, stall_o, 1'b0);
    chk({tag, "_rdv"}, rd_valid_o, 1'b0);
    chk({tag, "_err"}, err_o, 1'b0);
    chk({tag, "_rdata"}, rd_data_o, exp_rd_data);
  endtask

  // One operation from an idle controller. d = index of the WAIT_ACK cycle
  // carrying the ack (d >= TO means the ack never comes).
  task automatic run_op(input logic ld, input logic st, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input int d, input logic [DW-1:0] rdata,
                        input logic ack_outside);
    int w;
    bit aborted;
    step();
    ex_valid_i    = 1'b1;
    ex_is_load_i  = ld;
    ex_is_store_i = st;
    ex_addr_i     = addr;
    ex_wdata_i    = wd;
    dmem_ack_i    = ack_outside;
    dmem_rdata_i  = $urandom;
    if (ld ^ st) begin
      sample();
      chk("acc_stall", stall_o, 1'b1);
      chk("acc_req", dmem_req_o, 1'b0);
      chk("acc_err", err_o, 1'b0);
      exp_we = st;
      if (st) exp_wdata = wd;
      aborted = (d >= TO);
      w = aborted ? TO : d + 1;
      for (int i = 0; i < w; i++) begin
        step();
        dmem_ack_i   = (i == d);
        dmem_rdata_i = (i == d) ? rdata : $urandom;
        sample();
        chk("wait_req", dmem_req_o, 1'b1);
        chk("wait_stall", stall_o, 1'b1);
        chk("wait_addr", dmem_addr_o, addr);
        chk("wait_we", dmem_we_o, exp_we);
        chk("wait_wdata", dmem_wdata_o, exp_wdata);
        chk("wait_rdv", rd_valid_o, 1'b0);
        chk("wait_err", err_o, 1'b0);
        chk("wait_rdata", rd_data_o, exp_rd_data);
      end
      step();
      ex_valid_i   = 1'b0;
      dmem_ack_i   = ack_outside;
      dmem_rdata_i = $urandom;
      if (aborted) exp_rd_data = '0;
      else if (ld) exp_rd_data = rdata;
      sample();
      chk("resp_req", dmem_req_o, 1'b0);
      chk("resp_stall", stall_o, 1'b0);
      chk("resp_rdv", rd_valid_o, ld);
      chk("resp_err", err_o, aborted);
      chk("resp_rdata", rd_data_o, exp_rd_data);
      step();
      dmem_ack_i = ack_outside;
      sample();
      chk_quiet("post");
      chk("post_we", dmem_we_o, exp_we);
      chk("post_wdata", dmem_wdata_o, exp_wdata);
    end else begin
      sample();
      chk("ill_stall", stall_o, 1'b0);
      chk("ill_req", dmem_req_o, 1'b0);
      chk("ill_err0", err_o, 1'b0);
      step();
      ex_valid_i = 1'b0;
      sample();
      chk("ill_err1", err_o, 1'b1);
      chk("ill_req1", dmem_req_o, 1'b0);
      chk("ill_rdv1", rd_valid_o, 1'b0);
      step();
      sample();
      chk_quiet("ill_after");
      chk("ill_we", dmem_we_o, exp_we);
    end
    ex_valid_i    = 1'b0;
    ex_is_load_i  = 1'b0;
    ex_is_store_i = 1'b0;
    dmem_ack_i    = 1'b0;
  endtask

  initial begin
    int kind;
    int d;
    #3;
    chk_quiet("rst");
    chk("rst_addr", dmem_addr_o, '0);
    chk("rst_we", dmem_we_o, 1'b0);
    chk("rst_wdata", dmem_wdata_o, '0);
    repeat (2) @(negedge clk_i);
    arst_ni = 1'b1;

    run_op(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    run_op(1'b0, 1'b1, 32'h20, 32'h0000_00A5, 2, 32'h1234_5678, 1'b0);
    run_op(1'b1, 1'b0, 32'h30, 32'h0, TO + 5, 32'h0, 1'b0);
    run_op(1'b1, 1'b0, 32'h40, 32'h0, TO - 1, 32'hCAFE_F00D, 1'b1);
    run_op(1'b1, 1'b1, 32'h50, 32'h77, 0, 32'h0, 1'b0);
    run_op(1'b0, 1'b0, 32'h54, 32'h77, 0, 32'h0, 1'b1);

    // Reset pulse in the middle of a load that never gets acked.
    step();
    ex_valid_i   = 1'b1;
    ex_is_load_i = 1'b1;
    ex_addr_i    = 32'h60;
    step();
    sample();
    chk("mid_req_a", dmem_req_o, 1'b1);
    step();
    sample();
    chk("mid_req_b", dmem_req_o, 1'b1);
    #1;
    arst_ni      = 1'b0;
    ex_valid_i   = 1'b0;
    ex_is_load_i = 1'b0;
    #1;
    exp_rd_data = '0;
    exp_wdata   = '0;
    exp_we      = 1'b0;
    chk_quiet("mid_rst");
    chk("mid_rst_wdata", dmem_wdata_o, '0);
    @(negedge clk_i);
    arst_ni = 1'b1;
    step();
    sample();
    chk_quiet("after_rst");
    run_op(1'b1, 1'b0, 32'h70, 32'h0, 1, 32'h0BAD_C0DE, 1'b0);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        d = $urandom_range(0, 1);
        run_op(d[0], d[0], $urandom, $urandom, 0, 32'h0, 1'($urandom_range(0, 1)));
      end else if (kind < 6) begin
        d = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 4);
        run_op(1'b1, 1'b0, $urandom, $urandom, d, $urandom, 1'($urandom_range(0, 1)));
      end else begin
        d = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 3, TO - 1) : $urandom_range(0, 4);
        run_op(1'b0, 1'b1, $urandom, $urandom, d, $urandom, 1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences data-memory accesses for the execution unit. It accepts a LOAD/STORE request from the execute stage and drives the DMEM req/ack handshake with registered, stable bus signals. It stalls the pipeline until the access completes, returns load data with a valid pulse, and aborts hung accesses with a timeout. It sits between the execution datapath and the DMEM port.

Parameters:
MEM_ADDR_WIDTH, simple_processor_pkg::ADDR_WIDTH (32), width of DMEM address bus
MEM_DATA_WIDTH, simple_processor_pkg::DATA_WIDTH (32), width of DMEM data bus and load result
TIMEOUT_CYCLES, 16, WAIT_ACK cycles without ack before abort; legal range 1..255

Ports:
clk_i  in  1  single clock; all state on rising edge
arst_ni  in  1  reset, asynchronous assert, active-low
ex_valid_i  in  1  execute stage presents a memory op this cycle
ex_is_load_i  in  1  op is LOAD
ex_is_store_i  in  1  op is STORE
ex_addr_i  in  MEM_ADDR_WIDTH  access address (rs1 value)
ex_wdata_i  in  MEM_DATA_WIDTH  store data (rs2 value)
stall_o  out  1  hold execute stage; ex_* stay stable while high
rd_data_o  out  MEM_DATA_WIDTH  last completed load data
rd_valid_o  out  1  one-cycle pulse, load completed
err_o  out  1  one-cycle pulse: timeout or illegal op
dmem_req_o  out  1  DMEM request active
dmem_addr_o  out  MEM_ADDR_WIDTH  registered address
dmem_we_o  out  1  1 = store, 0 = load
dmem_wdata_o  out  MEM_DATA_WIDTH  registered store data
dmem_rdata_i  in  MEM_DATA_WIDTH  DMEM read data, valid with ack
dmem_ack_i  in  1  DMEM access complete

Behaviour:
- Reset (arst_ni low, async): state IDLE; all outputs 0; counter 0. Asserting reset mid-access drops dmem_req_o immediately, with no completion and no err.
- FSM states: IDLE, WAIT_ACK, RESP.
- Accept condition: in IDLE, when ex_valid_i=1 and exactly one of load/store is high.
  - Same cycle: stall_o=1 (combinational).
  - Clock edge: register addr, wdata and we (=store); go to WAIT_ACK.
- Illegal op: in IDLE, ex_valid_i=1 with load and store both high, or both low.
  - Op is not accepted; stall_o=0; err_o pulses next cycle.
- WAIT_ACK:
  - dmem_req_o=1 and stall_o=1.
  - addr/we/wdata held constant for the whole state.
  - Counter increments each cycle.
  - On dmem_ack_i=1: if load, capture dmem_rdata_i into rd_data_o; go to RESP.
  - If the counter reaches TIMEOUT_CYCLES with no ack: go to RESP with abort flag set.
- RESP:
  - dmem_req_o=0, stall_o=0, counter cleared.
  - rd_valid_o=1 if the op was a load.
  - On abort: err_o=1 and rd_data_o=0.
  - Next state is always IDLE, so back-to-back ops get one idle cycle between accesses.
- Latency: accept in cycle N; dmem_req_o rises in N+1; earliest ack in N+1; RESP and rd_valid_o in N+2. Stall covers cycles N..N+1.
- dmem_ack_i outside WAIT_ACK is ignored.
- rd_data_o holds its value until the next completed load or abort. A store never changes it.
- Ack arriving in the same cycle the counter hits the limit: ack wins, no err.
- dmem_we_o and dmem_wdata_o keep their last values after completion; dmem_wdata_o is updated only when a store is accepted.

Test Plan:
- Reset, then load at addr 0x10 with ack in the first WAIT_ACK cycle and rdata 0xDEADBEEF -> dmem_req_o high for 1 cycle, addr 0x10, we 0; stall_o high for 2 cycles; rd_valid_o pulses with rd_data_o=0xDEADBEEF.
- Store of 0x0000_00A5 to 0x20 with ack after 3 cycles -> req, addr, wdata and we=1 stable for 3 cycles; stall_o high for 4 cycles; no rd_valid_o; rd_data_o unchanged.
- Load with ack never returned, TIMEOUT_CYCLES=16 -> req high for exactly 16 cycles, then err_o and rd_valid_o pulse together with rd_data_o=0; FSM returns to IDLE.
- Ack in the 16th WAIT_ACK cycle -> normal completion, err_o stays 0.
- ex_valid_i with load and store both high -> no req, stall_o=0, err_o pulses once.
- arst_ni pulled low for 1 cycle mid WAIT_ACK -> dmem_req_o drops asynchronously; after release, a new load completes normally with no spurious rd_valid_o.
